// File: rtl/io_hex_ctrl.sv
// Bus front end for the two-digit hex display: byte FIFO, timed hold FSM, status reads.
// Optional drain interrupt is enabled by defining IO_HEX_IRQ_EN.
module io_hex_ctrl #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned HOLD_CYCLES = 12_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  input  logic       we,
  input  logic       addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       ack,
  output logic [7:0] hex_val,
  output logic       irq
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t        state;
  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [HW-1:0] cnt;

  logic full, empty, accept, push, ctrl_wr, flush, expire, pop, irq_bit;
  logic [7:0] status;

  always_comb begin
    full    = (count == CW'(DEPTH));
    empty   = (count == '0);
    // Full-stall uses the pre-edge count, so a pop in the same cycle does not unblock it.
    accept  = req & ~ack & ~(we & ~addr & full);
    push    = accept & we & ~addr;
    ctrl_wr = accept & we & addr;
    flush   = ctrl_wr & wdata[0];
    expire  = (state == HOLD) && (cnt == HOLD_LAST);
    pop     = ~flush & ~empty & ((state == IDLE) | expire);
    status  = {state == HOLD, irq_bit, full, empty, 4'(count)};
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      cnt     <= '0;
      hex_val <= '0;
      rdata   <= '0;
      ack     <= 1'b0;
    end else begin
      ack <= accept;
      if (accept && !we) rdata <= addr ? status : hex_val;
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
        cnt    <= '0;
        state  <= IDLE;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop) begin
          rd_ptr  <= rd_ptr + PW'(1);
          hex_val <= mem[rd_ptr];
        end
        count <= count + CW'(push) - CW'(pop);
        case (state)
          IDLE: begin
            if (pop) begin
              cnt   <= '0;
              state <= HOLD;
            end
          end
          HOLD: begin
            if (expire) begin
              cnt <= '0;
              if (!pop) state <= IDLE;
            end else begin
              cnt <= cnt + HW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef IO_HEX_IRQ_EN
  logic irq_pend;
  logic drain;

  // Drain: hold expires with nothing queued; a flush cancels the natural expiry.
  assign drain = expire & empty & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_pend <= 1'b0;
    end else if (drain) begin
      irq_pend <= 1'b1;
    end else if (ctrl_wr && wdata[1]) begin
      irq_pend <= 1'b0;
    end
  end

  assign irq     = irq_pend;
  assign irq_bit = irq_pend;
`else
  assign irq     = 1'b0;
  assign irq_bit = 1'b0;
`endif

endmodule
